// File: rtl/gf163_reduce.sv
// gf163_reduce
// Reduces a 325-bit unreduced GF(2) polynomial product modulo
// f(x) = x^163 + x^7 + x^6 + x^3 + 1 using repeated folding of the high half.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears state and accumulator)
//   in_valid   unreduced product present on c
//   in_ready   block can accept a product (IDLE and not in reset)
//   c[324:0]   unreduced product, bit i = coefficient of x^i
//   out_valid  reduced result present on d (HOLD state)
//   out_ready  downstream accepts d
//   d[162:0]   c mod f(x), taken directly from the low accumulator bits
//
// Compile-time option:
//   GF163_REDUCE_ONECYCLE_EN  perform both folds in a single cycle (no F2 state),
//                             giving one-edge latency; results are identical.
module gf163_reduce (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [324:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] d
);

    localparam int unsigned M  = 163;        // field degree
    localparam int unsigned W  = 325;        // unreduced product width
    localparam int unsigned HW = W - M;      // high-part width (162)

    // x^163 == x^7 + x^6 + x^3 + 1, so the high part folds back as
    // hi * (1 + x^3 + x^6 + x^7) onto the low part.
    function automatic logic [W-1:0] fold(input logic [W-1:0] x);
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        hi   = {{M{1'b0}}, x[W-1:M]};
        lo   = {{HW{1'b0}}, x[M-1:0]};
        fold = lo ^ hi ^ (hi << 3) ^ (hi << 6) ^ (hi << 7);
    endfunction

`ifdef GF163_REDUCE_ONECYCLE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F1   = 2'd1,
        HOLD = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F1   = 2'd1,
        F2   = 2'd2,
        HOLD = 2'd3
    } state_t;
`endif

    state_t       state;
    state_t       state_next;
    logic [W-1:0] acc;
    logic [W-1:0] acc_next;

    // State and accumulator registers; reset clears both without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
        end
    end

    // Next-state and accumulator update.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_next   = c;
                    state_next = F1;
                end
            end
`ifdef GF163_REDUCE_ONECYCLE_EN
            F1: begin
                acc_next   = fold(fold(acc));
                state_next = HOLD;
            end
`else
            F1: begin
                acc_next   = fold(acc);
                state_next = F2;
            end
            // After the second fold the high part is guaranteed zero.
            F2: begin
                acc_next   = fold(acc);
                state_next = HOLD;
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs derive directly from registered state; in_ready is masked
    // during reset so nothing can be accepted while it is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);
    assign d         = acc[M-1:0];

endmodule

// File: tb/tb_gf163_reduce.sv
// tb_gf163_reduce
// Self-checking bench for gf163_reduce: directed scenarios followed by a
// randomized handshake stream checked against a long-division reference.
module tb_gf163_reduce;

`ifdef GF163_REDUCE_ONECYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int NRAND = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [324:0] c;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] d;

    int errors = 0;
    int checks = 0;

    gf163_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [324:0] obs, input logic [324:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: schoolbook polynomial long division by f(x).
    function automatic logic [162:0] ref_mod(input logic [324:0] x);
        logic [324:0] r;
        logic [324:0] f;
        r = x;
        f = '0;
        f[163] = 1'b1;
        f[7]   = 1'b1;
        f[6]   = 1'b1;
        f[3]   = 1'b1;
        f[0]   = 1'b1;
        for (int i = 324; i >= 163; i--) begin
            if (r[i]) r = r ^ (f << (i - 163));
        end
        return r[162:0];
    endfunction

    function automatic logic [324:0] rand_c();
        logic [324:0] r;
        r = '0;
        for (int i = 0; i < 11; i++) r = (r << 32) | 325'($urandom);
        return r;
    endfunction

    // Called at a negedge with in_ready=1; returns at the negedge after the accept edge.
    task automatic send(input logic [324:0] cv);
        in_valid = 1'b1;
        c        = cv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c        = rand_c();
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("out_valid_timeout", 325'(out_valid), 325'(1));
    endtask

    initial begin
        logic [324:0] cv;
        logic [162:0] e;
        logic [162:0] q[$];
        int n;
        int got;
        int sent;
        int cyc;
        bit took;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c         = '0;

        // Reset state
        #1;
        chk("rst_in_ready", 325'(in_ready), 325'(0));
        chk("rst_out_valid", 325'(out_valid), 325'(0));
        chk("rst_d", 325'(d), 325'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 325'(in_ready), 325'(1));

        // x^163 -> 0xC9, latency and single-cycle out_valid
        cv = '0;
        cv[163] = 1'b1;
        send(cv);
        chk("x163_ov_after_accept", 325'(out_valid), 325'(0));
        wait_out(n);
        chk("x163_latency", 325'(n), 325'(LAT));
        chk("x163_d", 325'(d), 325'(163'hC9));
        @(negedge clk);
        chk("x163_ov_one_cycle", 325'(out_valid), 325'(0));
        chk("x163_in_ready_back", 325'(in_ready), 325'(1));

        // x^324 -> bits {161,12,10,5,1}
        cv = '0;
        cv[324] = 1'b1;
        e = '0;
        e[161] = 1'b1;
        e[12]  = 1'b1;
        e[10]  = 1'b1;
        e[5]   = 1'b1;
        e[1]   = 1'b1;
        send(cv);
        wait_out(n);
        chk("x324_d", 325'(d), 325'(e));
        @(negedge clk);

        // Already-reduced input passes through
        cv = '0;
        cv[162] = 1'b1;
        cv[0]   = 1'b1;
        send(cv);
        wait_out(n);
        chk("noreduce_d", 325'(d), cv);
        @(negedge clk);

        // Backpressure in HOLD; in_valid there must be ignored
        out_ready = 1'b0;
        cv = rand_c();
        e  = ref_mod(cv);
        send(cv);
        wait_out(n);
        in_valid = 1'b1;
        c        = rand_c();
        for (int i = 0; i < 5; i++) begin
            chk("hold_d", 325'(d), 325'(e));
            chk("hold_out_valid", 325'(out_valid), 325'(1));
            chk("hold_in_ready", 325'(in_ready), 325'(0));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ov", 325'(out_valid), 325'(0));
        chk("hold_release_in_ready", 325'(in_ready), 325'(1));

        // Reset during F1 aborts the product
        send(rand_c());
        rst = 1'b1;
        #1;
        chk("abort_d", 325'(d), 325'(0));
        chk("abort_ov", 325'(out_valid), 325'(0));
        chk("abort_in_ready", 325'(in_ready), 325'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_after", 325'(in_ready), 325'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_result", 325'(out_valid), 325'(0));
        end
        cv = rand_c();
        send(cv);
        wait_out(n);
        chk("after_abort_d", 325'(d), 325'(ref_mod(cv)));
        chk("after_abort_latency", 325'(n), 325'(LAT));
        @(negedge clk);

        // Random stream with random handshakes; results must come out in order
        got  = 0;
        sent = 0;
        cyc  = 0;
        took = 1'b0;
        while (got < NRAND && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (took) begin
                in_valid = 1'b0;
                took     = 1'b0;
            end
            if (!in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                c        = rand_c();
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 325'(1), 325'(0));
                end else begin
                    chk("rand_d", 325'(d), 325'(q.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mod(c));
                sent++;
                took = 1'b1;
            end
        end
        chk("rand_count", 325'(got), 325'(NRAND));
        chk("rand_queue_empty", 325'(q.size()), 325'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf163_reduce.md
GF163_REDUCE -- requirements
Module: gf163_reduce

Interface
REQ-001 SHALL have these ports, one clock; reset is asynchronous and active-high:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  unreduced product present on c
- in_ready  output  1  block can accept a product
- c  input  325  unreduced GF(2) polynomial product, bit i = coefficient of x^i (degree <= 324)
- out_valid  output  1  reduced result present on d
- out_ready  input  1  downstream accepts d
- d  output  163  c mod f(x), f(x) = x^163 + x^7 + x^6 + x^3 + 1

REQ-002 SHALL have no parameters; all widths are fixed as above.

Function
REQ-003 SHALL implement an FSM with states IDLE, F1, F2 and HOLD, with a 325-bit accumulator acc.
REQ-004 in_ready SHALL equal (state==IDLE) AND NOT rst.
REQ-005 out_valid SHALL equal (state==HOLD).
REQ-006 d SHALL equal acc[162:0] at all times; d is meaningful only while out_valid=1.
REQ-007 Accept edge: in_valid=1 and in_ready=1 SHALL load acc<=c and move the FSM to F1; c is sampled only at this edge.
REQ-008 fold(x) SHALL be defined as lo ^ hi ^ (hi<<3) ^ (hi<<6) ^ (hi<<7), where hi=x[324:163] and lo=x[162:0], zero-extended to 325 bits.
REQ-009 F1 SHALL load acc<=fold(acc) and go to F2; F2 SHALL load acc<=fold(acc) and go to HOLD.
REQ-010 After the F2 edge, acc[324:163] SHALL be zero, because two folds are sufficient for degree <= 324.
REQ-011 Latency: out_valid SHALL rise on the 2nd rising edge after the accept edge (default build).
REQ-012 HOLD with out_ready=1 SHALL complete the output handshake and return to IDLE on that edge.
REQ-013 HOLD with out_ready=0 SHALL keep the state, and d SHALL stay stable for any number of cycles.
REQ-014 There SHALL be no overlap: a new accept is possible no earlier than the edge after the output handshake, so peak throughput is one result per 4 cycles (default build).
REQ-015 in_valid seen in F1, F2 or HOLD SHALL be ignored; the upstream holds its data, since in_ready=0.
REQ-016 out_ready in any state other than HOLD SHALL have no effect.
REQ-017 The state is transient: it SHALL not persist across handshakes, and the acc contents after a handoff are don't-care until the next accept.

Reset
REQ-018 rst=1 SHALL immediately, without waiting for clk, set state=IDLE and acc=0; this gives d=0, out_valid=0 and in_ready=0.
REQ-019 Reset asserted in F1, F2 or HOLD SHALL abort the operation: no out_valid is ever produced for the aborted product.
REQ-020 On the first edge after rst deasserts, in_ready SHALL be 1, and an accept is legal on that edge.

Configuration
REQ-021 The macro GF163_REDUCE_ONECYCLE_EN SHALL be the only compile-time option.
REQ-022 With GF163_REDUCE_ONECYCLE_EN defined:
- state F2 SHALL be removed;
- F1 SHALL load acc<=fold(fold(acc)) and go directly to HOLD;
- out_valid SHALL rise on the 1st edge after accept;
- peak throughput SHALL be one result per 3 cycles.
REQ-023 Without the macro, the two-stage behaviour of REQ-009 and REQ-011 SHALL apply. Results SHALL be bit-identical in both builds.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- c = 1<<163, out_ready=1 -> d = 163'hC9; out_valid high exactly 1 cycle, 2 edges after accept (1 edge with the macro).
- c = 1<<324 -> d has bits {161,12,10,5,1} set and all others zero.
- c = 1<<162 | 1 -> d = c[162:0] unchanged (no reduction needed).
- Hold out_ready=0 for 5 cycles in HOLD -> d stable, out_valid=1, in_ready=0 throughout; raise out_ready -> IDLE next edge, in_ready=1.
- Assert rst for 1 cycle while in F1 -> out_valid stays 0, d=0 immediately, no result emitted; the next product is reduced correctly.
- 1000 random c with random in_valid/out_ready -> every d equals a software reference of c mod f(x), in order; no result is lost or duplicated.
